lsu: RTL and testbench

LSU -- requirements
Module: lsu

---
 rtl/lsu.sv | 133 +++++++++++++
 tb/tb_lsu.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
// Load/store unit: single-cycle loads and word stores, read-modify-write for
// byte/halfword stores through a one-cycle MERGE state.
module lsu #(
    parameter int MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    // Handshake: a request is taken on any rising edge where req_valid && req_ready;
    // resp_valid is a one-cycle pulse with no backpressure.
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] MERGE = 1'b1;
    localparam logic [31:0] MEM_WORDS_W = 32'(MEM_WORDS);

    logic [0:0]  state;
    logic [31:0] lat_addr;
    logic [15:0] lat_data;
    logic        lat_half;

    logic        legal;
    logic        misaligned;
    logic        out_of_range;
    logic        err;
    logic        accept;
    logic        sub_store;
    logic        word_store;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;
    logic [4:0]  byte_sh;
    logic [31:0] merge_mask;
    logic [31:0] merge_data;
    logic [31:0] merged;

    assign req_ready = reset_n && (state == IDLE);
    assign accept    = req_valid && req_ready;

    always_comb begin
        legal = 1'b0;
        case (req_funct3)
            3'b000, 3'b001, 3'b010: legal = 1'b1;
            3'b100, 3'b101:         legal = !req_we;
            default:                legal = 1'b0;
        endcase
        misaligned   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                       ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        out_of_range = {2'b00, req_addr[31:2]} >= MEM_WORDS_W;
        err          = !legal || misaligned || out_of_range;
        sub_store    = req_we && !err && (req_funct3[1] == 1'b0);
        word_store   = req_we && !err && (req_funct3 == 3'b010);
    end

    always_comb begin
        ld_byte = 8'h00;
        case (req_addr[1:0])
            2'd0: ld_byte = mem_rd[7:0];
            2'd1: ld_byte = mem_rd[15:8];
            2'd2: ld_byte = mem_rd[23:16];
            2'd3: ld_byte = mem_rd[31:24];
            default: ld_byte = 8'h00;
        endcase
        ld_half = req_addr[1] ? mem_rd[31:16] : mem_rd[15:0];
        ld_data = 32'h0;
        case (req_funct3)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b010:  ld_data = mem_rd;
            3'b100:  ld_data = {24'h0, ld_byte};
            3'b101:  ld_data = {16'h0, ld_half};
            default: ld_data = 32'h0;
        endcase
    end

    // Replicate the latched data across the word, then keep only the target lane.
    always_comb begin
        byte_sh = {lat_addr[1:0], 3'b000};
        if (lat_half) begin
            merge_mask = lat_addr[1] ? 32'hffff_0000 : 32'h0000_ffff;
            merge_data = {2{lat_data}};
        end else begin
            merge_mask = 32'h0000_00ff << byte_sh;
            merge_data = {4{lat_data[7:0]}};
        end
        merged = (mem_rd & ~merge_mask) | (merge_data & merge_mask);
    end

    always_comb begin
        mem_a  = (state == MERGE) ? lat_addr : req_addr;
        mem_wd = (state == MERGE) ? merged : req_wdata;
        mem_we = reset_n && ((state == MERGE) || (accept && word_store));
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'h0;
        end else begin
            resp_valid <= accept && (err || !req_we);
            resp_err   <= accept && err;
            resp_rdata <= (accept && !err && !req_we) ? ld_data : 32'h0;
            case (state)
                IDLE:    state <= (accept && sub_store) ? MERGE : IDLE;
                MERGE:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            lat_addr <= req_addr;
            lat_data <= req_wdata[15:0];
            lat_half <= req_funct3[0];
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed scenarios plus random loads/stores
// compared against a byte-level memory model.
module tb_lsu;

    localparam int MEM_WORDS = 1024;

    logic        clk;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    logic [31:0] mem [0:MEM_WORDS-1];
    logic [31:0] ref_mem [0:MEM_WORDS-1];
    logic [31:0] exp_q[$];
    logic [31:0] last_rd;

    int n_checks = 0;
    int n_errors = 0;

    lsu #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_we     (mem_we),
        .mem_a      (mem_a),
        .mem_wd     (mem_wd),
        .mem_rd     (mem_rd)
    );

    // clock / memory
    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rd = mem[mem_a[11:2]];

    always @(posedge clk) begin
        if (mem_we) mem[mem_a[11:2]] <= mem_wd;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit is_legal(input logic we, input logic [2:0] f3);
        if (we) return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
        return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    endfunction

    function automatic bit is_err(input logic we, input logic [2:0] f3, input logic [31:0] addr);
        int sz;
        sz = 1 << f3[1:0];
        return !is_legal(we, f3) || ((addr % sz) != 0) || ((addr >> 2) >= MEM_WORDS);
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr);
        logic [31:0] w;
        logic [31:0] v;
        int sz;
        sz = 1 << f3[1:0];
        w  = ref_mem[addr[11:2]] >> (8 * (addr % 4));
        if (sz == 4) return ref_mem[addr[11:2]];
        if (sz == 1) begin
            v = w & 32'hff;
            if (f3 == 3'd0 && v[7]) v = v | 32'hffff_ff00;
        end else begin
            v = w & 32'hffff;
            if (f3 == 3'd1 && v[15]) v = v | 32'hffff_0000;
        end
        return v;
    endfunction

    function automatic logic [31:0] model_store(input logic [2:0] f3, input logic [31:0] addr,
                                                input logic [31:0] wdata);
        logic [31:0] w;
        int sz;
        int off;
        sz  = 1 << f3[1:0];
        off = int'(addr % 4);
        w   = ref_mem[addr[11:2]];
        for (int b = 0; b < sz; b++) w[8*(off+b) +: 8] = wdata[8*b +: 8];
        return w;
    endfunction

    task automatic set_word(input logic [31:0] addr, input logic [31:0] val);
        mem[addr[11:2]]     = val;
        ref_mem[addr[11:2]] = val;
    endtask

    // driver: called just after a falling edge; returns just after a falling edge
    task automatic do_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata);
        bit          e;
        bit          sw;
        bit          sub;
        logic [31:0] exp_rd;
        logic [31:0] new_w;
        e      = is_err(we, f3, addr);
        sw     = !e && we && (f3 == 3'd2);
        sub    = !e && we && (f3 != 3'd2);
        exp_rd = (!e && !we) ? model_load(f3, addr) : 32'h0;
        new_w  = (!e && we) ? model_store(f3, addr, wdata) : ref_mem[addr[11:2]];
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        #1;
        check("acc_ready", 32'(req_ready), 32'd1);
        check("acc_mem_we", 32'(mem_we), 32'(sw));
        check("acc_mem_a", mem_a, addr);
        if (sw) check("acc_mem_wd", mem_wd, wdata);
        @(negedge clk);
        #1;
        req_valid = 1'b0;
        #1;
        check("resp_valid", 32'(resp_valid), 32'(e || !we));
        check("resp_err", 32'(resp_err), 32'(e));
        check("resp_rdata", resp_rdata, exp_rd);
        last_rd = resp_rdata;
        if (sub) begin
            check("merge_ready", 32'(req_ready), 32'd0);
            check("merge_we", 32'(mem_we), 32'd1);
            check("merge_wd", mem_wd, new_w);
            @(negedge clk);
            #1;
            check("post_merge_ready", 32'(req_ready), 32'd1);
        end else begin
            check("idle_mem_we", 32'(mem_we), 32'd0);
        end
        ref_mem[addr[11:2]] = new_w;
        check("mem_word", mem[addr[11:2]], ref_mem[addr[11:2]]);
    endtask

    task automatic load_burst(input logic [31:0] base, input int n);
        logic [31:0] a;
        int          timeout;
        for (int i = 0; i < n; i++) begin
            a = base + 32'(4 * i);
            req_valid  = 1'b1;
            req_we     = 1'b0;
            req_funct3 = 3'd2;
            req_addr   = a;
            req_wdata  = 32'h0;
            #1;
            check("burst_ready", 32'(req_ready), 32'd1);
            if (i > 0) begin
                check("burst_valid", 32'(resp_valid), 32'd1);
                check("burst_rdata", resp_rdata, exp_q.pop_front());
            end
            exp_q.push_back(ref_mem[a[11:2]]);
            @(negedge clk);
            #1;
        end
        req_valid = 1'b0;
        #1;
        timeout = 0;
        while (exp_q.size() > 0 && timeout < 4) begin
            if (resp_valid) check("burst_tail", resp_rdata, exp_q.pop_front());
            @(negedge clk);
            #1;
            timeout++;
        end
        check("burst_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        check("burst_quiet", 32'(resp_valid), 32'd0);
    endtask

    initial begin
        reset_n    = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        last_rd    = 32'h0;
        for (int i = 0; i < MEM_WORDS; i++) set_word(32'(4 * i), $urandom);

        // reset
        repeat (3) @(negedge clk);
        #1;
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_valid", 32'(resp_valid), 32'd0);
        check("rst_err", 32'(resp_err), 32'd0);
        check("rst_rdata", resp_rdata, 32'h0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        reset_n = 1'b1;
        #1;
        check("rst_release_ready", 32'(req_ready), 32'd1);

        // sub-word loads
        set_word(32'h100, 32'h8bad_f00d);
        do_op(1'b0, 3'd0, 32'h103, 32'h0); check("lb_103", last_rd, 32'hffff_ff8b);
        do_op(1'b0, 3'd4, 32'h103, 32'h0); check("lbu_103", last_rd, 32'h0000_008b);
        do_op(1'b0, 3'd1, 32'h102, 32'h0); check("lh_102", last_rd, 32'hffff_8bad);
        do_op(1'b0, 3'd5, 32'h102, 32'h0); check("lhu_102", last_rd, 32'h0000_8bad);

        // byte store merge, then immediate load
        set_word(32'h40, 32'h1122_3344);
        do_op(1'b1, 3'd0, 32'h41, 32'haa);
        check("sb_mem", mem[16], 32'h1122_aa44);
        do_op(1'b0, 3'd2, 32'h40, 32'h0); check("lw_after_sb", last_rd, 32'h1122_aa44);

        // misaligned, out-of-range, illegal funct3
        do_op(1'b1, 3'd2, 32'h202, 32'hdead_beef);
        do_op(1'b0, 3'd1, 32'h101, 32'h0);
        do_op(1'b0, 3'd2, 32'h1000, 32'h0);
        do_op(1'b0, 3'd3, 32'h0, 32'h0);
        do_op(1'b1, 3'd5, 32'h10, 32'h1234);

        // reset during MERGE aborts the halfword write
        set_word(32'h10, 32'h5566_7788);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'd1;
        req_addr   = 32'h12;
        req_wdata  = 32'hbeef;
        @(negedge clk);
        #1;
        req_valid = 1'b0;
        reset_n   = 1'b0;
        #1;
        check("rst_merge_we", 32'(mem_we), 32'd0);
        check("rst_merge_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        #1;
        reset_n = 1'b1;
        #1;
        check("rst_merge_after_ready", 32'(req_ready), 32'd1);
        check("rst_merge_after_we", 32'(mem_we), 32'd0);
        check("rst_merge_mem", mem[4], 32'h5566_7788);

        // back-to-back loads
        load_burst(32'h0, 4);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            logic        we;
            logic [2:0]  f3;
            logic [31:0] a;
            we = 1'($urandom_range(0, 1));
            f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7))
                                              : 3'($urandom_range(0, 2));
            if (!we && $urandom_range(0, 3) == 0) f3 = 3'($urandom_range(4, 5));
            a  = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 255));
            if (f3[1:0] == 2'd1 && $urandom_range(0, 3) != 0) a[0] = 1'b0;
            if (f3[1:0] == 2'd2 && $urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            if ($urandom_range(0, 31) == 0) load_burst(32'($urandom_range(0, 60)) << 2, 4);
            else do_op(we, f3, a, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        n_errors++;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
